// File: rtl/launch_pkg.sv
// launch_pkg: shared types and default constants for the program launcher.
//   launch_state_t : sequencer FSM state encoding
//   DEF_*          : default parameter values for prog_launcher
//   sel_width()    : program-index width, never less than one bit
package launch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    RUN    = 3'd2,
    RECORD = 3'd3,
    FINISH = 3'd4
  } launch_state_t;

  localparam int DEF_NUM_PROGS  = 3;
  localparam int DEF_START_HOLD = 2;
  localparam int DEF_TIMEOUT    = 4096;
  localparam int DEF_CNT_W      = 16;

  // A single program still needs a one-bit index port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_timer.sv
// run_timer: clearable, enabled up-counter with terminal-count detect.
//   clk_i  : clock (posedge)
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   cnt_o  : current count
//   tc_o   : high when the incremented count would equal LIMIT
module run_timer
  import launch_pkg::*;
#(
  parameter int W     = DEF_CNT_W,
  parameter int LIMIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + W'(1);
  // Terminal count looks one step ahead so the owner can act on the same edge.
  assign tc_o      = (cnt_inc_s == W'(LIMIT));
  assign cnt_o     = cnt_q;

  // Next count: clear, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// prog_launcher: sequences NUM_PROGS programs through a processor's Start/Ack
// handshake, measuring each run and aborting runaway programs.
//   Clk, Reset       : clock and synchronous active-high reset
//   Go               : launches a sequence (sampled in IDLE only)
//   Ack              : processor halted
//   Start            : holds processor; falling edge starts its PC
//   ProgSel          : index of the program being run
//   Busy             : sequence in progress
//   CountValid       : one-cycle pulse, CycleCount/CountProg updated
//   CycleCount       : run length of the last finished program
//   CountProg        : program index CycleCount belongs to
//   TimedOut         : sticky abort flag, cleared by the next accepted Go
//   Done             : one-cycle pulse at sequence end
module prog_launcher
  import launch_pkg::*;
#(
  parameter int NUM_PROGS  = DEF_NUM_PROGS,
  parameter int START_HOLD = DEF_START_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SEL_W      = sel_width(NUM_PROGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Ack,
  output logic             Start,
  output logic [SEL_W-1:0] ProgSel,
  output logic             Busy,
  output logic             CountValid,
  output logic [CNT_W-1:0] CycleCount,
  output logic [SEL_W-1:0] CountProg,
  output logic             TimedOut,
  output logic             Done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PROGS - 1);

  launch_state_t    state_q, state_d;
  logic [SEL_W-1:0] prog_sel_q, prog_sel_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [SEL_W-1:0] count_prog_q, count_prog_d;
  logic             timed_out_q, timed_out_d;

  logic [CNT_W-1:0] hold_cnt_unused_s;
  logic             hold_tc_s;
  logic [CNT_W-1:0] run_cnt_s;
  logic             run_tc_s;

  // Both timers sit at zero outside their own state, so entry always starts clean.
  run_timer #(.W(CNT_W), .LIMIT(START_HOLD)) u_hold_timer (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (state_q != HOLD),
    .en_i  (state_q == HOLD),
    .cnt_o (hold_cnt_unused_s),
    .tc_o  (hold_tc_s)
  );

  run_timer #(.W(CNT_W), .LIMIT(TIMEOUT)) u_run_timer (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (state_q != RUN),
    .en_i  ((state_q == RUN) && !Ack),
    .cnt_o (run_cnt_s),
    .tc_o  (run_tc_s)
  );

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; Ack is only looked at in RUN, so a stale halt is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Go ? HOLD : IDLE;
      HOLD:    state_d = hold_tc_s ? RUN : HOLD;
      RUN:     state_d = (Ack || run_tc_s) ? RECORD : RUN;
      RECORD:  state_d = (timed_out_q || (prog_sel_q == LAST_SEL)) ? FINISH : HOLD;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only.
  always_comb begin
    Start      = 1'b1;
    Busy       = 1'b1;
    CountValid = 1'b0;
    Done       = 1'b0;
    case (state_q)
      IDLE:    Busy       = 1'b0;
      RUN:     Start      = 1'b0;
      RECORD:  CountValid = 1'b1;
      FINISH:  Done       = 1'b1;
      default: Start      = 1'b1;
    endcase
  end

  // Datapath next values; Ack is tested before the timeout so it wins a tie.
  always_comb begin
    prog_sel_d    = prog_sel_q;
    cycle_count_d = cycle_count_q;
    count_prog_d  = count_prog_q;
    timed_out_d   = timed_out_q;
    case (state_q)
      IDLE: begin
        if (Go) begin
          prog_sel_d  = {SEL_W{1'b0}};
          timed_out_d = 1'b0;
        end else begin
          prog_sel_d  = prog_sel_q;
        end
      end
      RUN: begin
        if (Ack) begin
          cycle_count_d = run_cnt_s;
          count_prog_d  = prog_sel_q;
        end else if (run_tc_s) begin
          cycle_count_d = CNT_W'(TIMEOUT);
          count_prog_d  = prog_sel_q;
          timed_out_d   = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q;
        end
      end
      RECORD: begin
        if (!timed_out_q && (prog_sel_q != LAST_SEL)) begin
          prog_sel_d = prog_sel_q + SEL_W'(1);
        end else begin
          prog_sel_d = prog_sel_q;
        end
      end
      default: prog_sel_d = prog_sel_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prog_sel_q    <= {SEL_W{1'b0}};
      cycle_count_q <= {CNT_W{1'b0}};
      count_prog_q  <= {SEL_W{1'b0}};
      timed_out_q   <= 1'b0;
    end else begin
      prog_sel_q    <= prog_sel_d;
      cycle_count_q <= cycle_count_d;
      count_prog_q  <= count_prog_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign ProgSel    = prog_sel_q;
  assign CycleCount = cycle_count_q;
  assign CountProg  = count_prog_q;
  assign TimedOut   = timed_out_q;

endmodule
